// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game-state encoding and paddle constants for the ball controller and renderer
package game_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    POINT = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  localparam logic [2:0] NO_PADDLE   = 3'd7;
  localparam int         PADDLE_SPAN = 2;

  // A paddle at p covers columns p .. p+PADDLE_SPAN-1; compared in int so p+1 never wraps.
  function automatic logic paddle_hit(logic [2:0] paddle, int col);
    return (paddle != NO_PADDLE) && (col >= int'(paddle)) && (col < int'(paddle) + PADDLE_SPAN);
  endfunction

  function automatic logic [3:0] sat_inc(logic [3:0] s);
    return (s == 4'hF) ? s : s + 4'd1;
  endfunction

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - game-step divider: counts 0..CYCLES-1 and flags the wrap cycle
module step_timer #(
  parameter int CYCLES = 2500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic step
);

  localparam int CW = (CYCLES > 2) ? $clog2(CYCLES) : 1;

  logic [CW-1:0] count;

  assign step = (count == CW'(CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset || clear || step) count <= '0;
    else                        count <= count + 1'b1;
  end

endmodule

// File: rtl/ball_controller.sv
// rtl/ball_controller.sv - pong game-state engine: ball motion, paddle collision, scoring, serve/point/over sequencing
module ball_controller
  import game_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int BIT_OF_WIDTH = 3,
  parameter int STEP_CYCLES  = 2500000,
  parameter int POINT_HOLD   = 3,
  parameter int WIN_SCORE    = 5,
  parameter int SERVE_X      = 3,
  parameter int SERVE_Y      = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2:0]              player_top,
  input  logic [2:0]              player_down,
  output logic [BIT_OF_WIDTH-1:0] x_pos,
  output logic [BIT_OF_WIDTH-1:0] y_pos,
  output logic [3:0]              score_top,
  output logic [3:0]              score_down,
  output logic                    point,
  output logic                    game_over
);

  localparam int HW = (POINT_HOLD > 1) ? $clog2(POINT_HOLD) : 1;
  localparam logic [BIT_OF_WIDTH-1:0] EDGE_MAX = BIT_OF_WIDTH'(WIDTH - 1);
  localparam logic [BIT_OF_WIDTH-1:0] NEAR_BOT = BIT_OF_WIDTH'(WIDTH - 2);
  localparam logic [BIT_OF_WIDTH-1:0] HIT_BOT  = BIT_OF_WIDTH'(WIDTH - 3);
  localparam logic [BIT_OF_WIDTH-1:0] SX       = BIT_OF_WIDTH'(SERVE_X);
  localparam logic [BIT_OF_WIDTH-1:0] SY       = BIT_OF_WIDTH'(SERVE_Y);
  localparam logic [HW-1:0]           HOLD_END = HW'(POINT_HOLD - 1);

  game_state_t state, state_n;
  logic [BIT_OF_WIDTH-1:0] x_n, y_n, x_mv;
  logic [3:0]  st_n, sd_n;
  logic [HW-1:0] hold, hold_n;
  logic dx, dx_n, dx_mv;   // 1 = moving right
  logic dy, dy_n;          // 1 = moving down
  logic scorer_top, scorer_n, point_n, clear, step;

  step_timer #(.CYCLES(STEP_CYCLES)) u_step_timer (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .step  (step)
  );

  assign game_over = (state == OVER);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      x_pos      <= SX;
      y_pos      <= SY;
      dx         <= 1'b1;
      dy         <= 1'b1;
      score_top  <= '0;
      score_down <= '0;
      point      <= 1'b0;
      hold       <= '0;
      scorer_top <= 1'b0;
    end else begin
      state      <= state_n;
      x_pos      <= x_n;
      y_pos      <= y_n;
      dx         <= dx_n;
      dy         <= dy_n;
      score_top  <= st_n;
      score_down <= sd_n;
      point      <= point_n;
      hold       <= hold_n;
      scorer_top <= scorer_n;
    end
  end

  always_comb begin
    state_n  = state;
    x_n      = x_pos;
    y_n      = y_pos;
    dx_n     = dx;
    dy_n     = dy;
    st_n     = score_top;
    sd_n     = score_down;
    point_n  = 1'b0;
    hold_n   = hold;
    scorer_n = scorer_top;
    clear    = 1'b0;

    // Horizontal move first; a wall bounce turns around and still advances one column.
    dx_mv = dx;
    if (dx && x_pos == EDGE_MAX) begin
      dx_mv = 1'b0;
      x_mv  = x_pos - 1'b1;
    end else if (!dx && x_pos == '0) begin
      dx_mv = 1'b1;
      x_mv  = x_pos + 1'b1;
    end else begin
      x_mv  = dx ? x_pos + 1'b1 : x_pos - 1'b1;
    end

    case (state)
      IDLE: begin
        if (start) begin
          state_n = PLAY;
          clear   = 1'b1;
        end
      end
      PLAY: begin
        if (step) begin
          x_n  = x_mv;
          dx_n = dx_mv;
          if (dy && y_pos == NEAR_BOT) begin
            if (paddle_hit(player_down, int'(x_mv))) begin
              dy_n = 1'b0;
              y_n  = HIT_BOT;
            end else begin
              y_n      = EDGE_MAX;
              st_n     = sat_inc(score_top);
              point_n  = 1'b1;
              scorer_n = 1'b1;
              state_n  = POINT;
            end
          end else if (!dy && y_pos == BIT_OF_WIDTH'(1)) begin
            if (paddle_hit(player_top, int'(x_mv))) begin
              dy_n = 1'b1;
              y_n  = BIT_OF_WIDTH'(2);
            end else begin
              y_n      = '0;
              sd_n     = sat_inc(score_down);
              point_n  = 1'b1;
              scorer_n = 1'b0;
              state_n  = POINT;
            end
          end else begin
            y_n = dy ? y_pos + 1'b1 : y_pos - 1'b1;
          end
        end
      end
      POINT: begin
        if (step) begin
          if (hold == HOLD_END) begin
            hold_n = '0;
            if ((scorer_top ? score_top : score_down) == 4'(WIN_SCORE)) begin
              state_n = OVER;
            end else begin
              // Re-serve toward whoever conceded: top scoring means the bottom player receives.
              state_n = IDLE;
              x_n     = SX;
              y_n     = SY;
              dx_n    = 1'b1;
              dy_n    = scorer_top;
            end
          end else begin
            hold_n = hold + 1'b1;
          end
        end
      end
      OVER: begin
        if (start) begin
          state_n = IDLE;
          clear   = 1'b1;
          st_n    = '0;
          sd_n    = '0;
          x_n     = SX;
          y_n     = SY;
          dx_n    = 1'b1;
          dy_n    = 1'b1;
        end
      end
    endcase
  end

endmodule
